// File: rtl/mult_acc_pkg.sv
// Shared definitions for the multiply-accumulate stage: default widths, state
// encoding and the signed 32-bit clamp limits used by the MULT_ACC_SAT_EN build.
package mult_acc_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/mult_acc_sat.sv
// Combinational clamp of a wide signed sum to the signed 32-bit range,
// sign-extended back to ACC_W; sat flags that clamping happened.
module mult_acc_sat
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat
);

  // The value fits in 32 signed bits iff bits [ACC_W-1:31] are all equal.
  logic fits;
  assign fits = (&acc_in[ACC_W-1:31]) || !(|acc_in[ACC_W-1:31]);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    acc_out = acc_in;
    sat     = 1'b0;
    if (!fits) begin
      sat     = 1'b1;
      acc_out = acc_in[ACC_W-1] ? {{(ACC_W-32){SAT_MIN[31]}}, SAT_MIN}
                                : {{(ACC_W-32){SAT_MAX[31]}}, SAT_MAX};
    end
  end

endmodule

// File: rtl/mult_acc_stage.sv
// Frame accumulator for signed 32-bit multiplier products with valid/ready on
// both sides. Define MULT_ACC_SAT_EN to clamp the presented sum to signed 32 bits.
module mult_acc_stage
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_trunc,
  output logic             out_sat
);

  // Count value at which the current accept is the MAX_TERMS-th term.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_trunc_q, out_trunc_d;
  logic             out_sat_q, out_sat_d;

  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] res_acc;
  logic             res_sat;
  logic             accept;
  logic             close;

  assign sum      = acc_q + {{(ACC_W-32){in_prod[31]}}, in_prod};
  assign in_ready = (state_q != HOLD) && !clr;
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (cnt_q == CNT_LAST));

`ifdef MULT_ACC_SAT_EN
  mult_acc_sat #(.ACC_W(ACC_W)) u_sat (
    .acc_in  (sum),
    .acc_out (res_acc),
    .sat     (res_sat)
  );
`else
  assign res_acc = sum;
  assign res_sat = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_trunc_d = out_trunc_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      HOLD: begin
        // clr is ignored here: the pending result survives until taken.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        if (clr) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (close) begin
          out_acc_d   = res_acc;
          out_cnt_d   = cnt_q + 1'b1;
          out_trunc_d = !in_last;
          out_sat_d   = res_sat;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = HOLD;
        end else if (accept) begin
          acc_d   = sum;
          cnt_d   = cnt_q + 1'b1;
          state_d = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_trunc_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_trunc_q <= out_trunc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_cnt   = out_cnt_q;
  assign out_trunc = out_trunc_q;
  assign out_sat   = out_sat_q;

endmodule
